// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared external ALU.
// Each accepted request is issued to the ALU for one cycle, then its result is held until the owner takes it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic             armed_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             id_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;

    logic             pick1_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             rsp_fire_s;

    // Arbitration: a lone requester wins, a tie goes to prio_q; armed_q delays the first grant past reset release.
    always_comb begin
        pick1_s    = req1_valid & (~req0_valid | prio_q);
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        rsp_fire_s = 1'b0;
        if ((state_q == ST_IDLE) && armed_q) begin
            grant0_s = req0_valid & ~pick1_s;
            grant1_s = pick1_s;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
        if (state_q == ST_RESP) begin
            rsp_fire_s = id_q ? rsp1_ready : rsp0_ready;
        end else begin
            rsp_fire_s = 1'b0;
        end
    end

    // Sequencer: grant and latch operands, capture the ALU result, hold it until the owner consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            armed_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 3'b000;
            id_q         <= 1'b0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        a_q     <= grant1_s ? req1_a  : req0_a;
                        b_q     <= grant1_s ? req1_b  : req0_b;
                        op_q    <= grant1_s ? req1_op : req0_op;
                        id_q    <= grant1_s;
                        prio_q  <= grant0_s;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q        <= alu_result;
                    zero_q       <= alu_zero;
                    rsp0_valid_q <= ~id_q;
                    rsp1_valid_q <= id_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: supplies a behavioural ALU, runs directed vectors and a
// randomized phase checked against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_zero, alu_zero;
    logic [2:0]  alu_control;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return (a < b) ? 32'd1 : 32'd0;
            3'b011:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_control, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit id, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE with the response consumed immediately; starts and ends 1 after a rising edge.
    task automatic do_txn(input string name, input bit id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set_req(id, 1'b1, op, a, b);
        @(negedge clk);
        chk({name, "_ready"}, id ? req1_ready : req0_ready, 32'd1);
        chk({name, "_ready_other"}, id ? req0_ready : req1_ready, 32'd0);
        step();
        set_req(id, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        chk({name, "_exec_novalid"}, id ? rsp1_valid : rsp0_valid, 32'd0);
        chk({name, "_alu_a"}, alu_a, a);
        chk({name, "_alu_ctl"}, {29'd0, alu_control}, {29'd0, op});
        step();
        @(negedge clk);
        chk({name, "_rsp_valid"}, id ? rsp1_valid : rsp0_valid, 32'd1);
        chk({name, "_rsp_valid_other"}, id ? rsp0_valid : rsp1_valid, 32'd0);
        chk({name, "_result"}, rsp_result, res);
        chk({name, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
        step();
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    // Random-phase model state
    bit          busy, owner, prio_m, e0, e1, g0, g1;
    int          age;
    logic [31:0] exp_res, ea, eb;
    logic [2:0]  eop;

    initial begin
        vecs[0]  = '{"add_5_7",    3'b010, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{"and",        3'b000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0};
        vecs[2]  = '{"or",         3'b001, 32'd1,          32'd2,          32'd3,          1'b0};
        vecs[3]  = '{"sub_zero",   3'b110, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[4]  = '{"slt_3_7",    3'b111, 32'd3,          32'd7,          32'd1,          1'b0};
        vecs[5]  = '{"slt_unsgn",  3'b111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[6]  = '{"mul",        3'b011, 32'd6,          32'd7,          32'd42,         1'b0};
        vecs[7]  = '{"op100",      3'b100, 32'd3,          32'd4,          32'd0,          1'b1};
        vecs[8]  = '{"op101",      3'b101, 32'd9,          32'd4,          32'd0,          1'b1};
        vecs[9]  = '{"add_wrap",   3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[10] = '{"sub_wrap",   3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[11] = '{"mul_wrap",   3'b011, 32'h8000_0001,  32'd4,          32'd4,          1'b0};

        reset_n = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        set_req(1'b1, 1'b1, 3'b001, 32'd1, 32'd2);

        // Reset state, then contention with both requests held valid from release
        step(); step();
        @(negedge clk);
        chk("rst_ready0", req0_ready, 32'd0);
        chk("rst_ready1", req1_ready, 32'd0);
        chk("rst_rspv", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctl", {29'd0, alu_control}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_no_grant", {30'd0, req0_ready, req1_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("cont_first_r0", req0_ready, 32'd1);
        chk("cont_first_r1", req1_ready, 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cont_exec_r1", req1_ready, 32'd0);
        step();
        @(negedge clk);
        chk("cont_rsp0_valid", rsp0_valid, 32'd1);
        chk("cont_rsp0_result", rsp_result, 32'h0000_00F0);
        chk("cont_resp_r1", req1_ready, 32'd0);
        step();
        set_req(1'b0, 1'b1, 3'b010, 32'd5, 32'd7);
        @(negedge clk);
        chk("cont_second_r1", req1_ready, 32'd1);
        chk("cont_second_r0", req0_ready, 32'd0);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        chk("cont_rsp1_valid", rsp1_valid, 32'd1);
        chk("cont_rsp1_result", rsp_result, 32'd3);
        step();
        @(negedge clk);
        chk("cont_third_r0", req0_ready, 32'd1);
        chk("cont_third_r1", req1_ready, 32'd0);
        step();
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("cont_rsp0b_result", rsp_result, 32'd12);
        chk("cont_rsp1b_quiet", rsp1_valid, 32'd0);
        step();

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].name, i[0], vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);
        end

        // Backpressure on requester 1 while requester 0 waits; rsp0_ready is ignored meanwhile
        set_req(1'b1, 1'b1, 3'b011, 32'd6, 32'd7);
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_grant1", req1_ready, 32'd1);
        step();
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b0, 1'b1, 3'b010, 32'd100, 32'd23);
        @(negedge clk);
        chk("bp_exec_r0", req0_ready, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp1_valid, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd42);
            chk("bp_hold_r0", req0_ready, 32'd0);
            chk("bp_hold_rsp0", rsp0_valid, 32'd0);
            step();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_consume_r0", req0_ready, 32'd0);
        step();
        @(negedge clk);
        chk("bp_after_r0", req0_ready, 32'd1);
        chk("bp_after_rsp1", rsp1_valid, 32'd0);
        step();
        req0_valid = 1'b0;
        step();
        @(negedge clk);
        chk("bp_req0_result", rsp_result, 32'd123);
        step();

        // Asynchronous reset during EXEC discards the operation
        set_req(1'b0, 1'b1, 3'b010, 32'd1, 32'd1);
        @(negedge clk);
        chk("rmid_grant", req0_ready, 32'd1);
        step();
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rmid_alu_a", alu_a, 32'd0);
        chk("rmid_alu_ctl", {29'd0, alu_control}, 32'd0);
        chk("rmid_result", rsp_result, 32'd0);
        chk("rmid_rsp0", rsp0_valid, 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rmid_no_rsp0", rsp0_valid, 32'd0);
            step();
        end
        do_txn("post_reset_add", 1'b1, 3'b010, 32'd2, 32'd2, 32'd4, 1'b0);

        // Randomized phase from a fresh reset against the transaction-level model
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        busy = 1'b0; owner = 1'b0; prio_m = 1'b0; age = 0; g0 = 1'b0; g1 = 1'b0;
        ea = 32'd0; eb = 32'd0; eop = 3'b000; exp_res = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(n == 1 ? req1_valid : req0_valid) || (n == 1 ? g1 : g0)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        logic [31:0] ra, rb;
                        ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                        rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                        set_req(n[0], 1'b1, 3'($urandom_range(0, 7)), ra, rb);
                    end else begin
                        set_req(n[0], 1'b0, 3'b000, 32'd0, 32'd0);
                    end
                end
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0;
            if (!busy) begin
                if (req0_valid && req1_valid) begin
                    e0 = ~prio_m; e1 = prio_m;
                end else begin
                    e0 = req0_valid; e1 = req1_valid;
                end
            end
            chk("rnd_ready0", req0_ready, {31'd0, e0});
            chk("rnd_ready1", req1_ready, {31'd0, e1});
            chk("rnd_rsp0_valid", rsp0_valid, {31'd0, busy && age >= 1 && !owner});
            chk("rnd_rsp1_valid", rsp1_valid, {31'd0, busy && age >= 1 && owner});
            if (busy && age >= 1) begin
                chk("rnd_result", rsp_result, exp_res);
                chk("rnd_zero", {31'd0, rsp_zero}, {31'd0, exp_res == 32'd0});
            end
            chk("rnd_alu_a", alu_a, ea);
            chk("rnd_alu_b", alu_b, eb);
            chk("rnd_alu_ctl", {29'd0, alu_control}, {29'd0, eop});
            g0 = e0; g1 = e1;
            if (e0 || e1) begin
                busy = 1'b1; owner = e1; age = 0; prio_m = e0;
                ea = e1 ? req1_a : req0_a;
                eb = e1 ? req1_b : req0_b;
                eop = e1 ? req1_op : req0_op;
                exp_res = alu_ref(eop, ea, eb);
            end else if (busy) begin
                if (age >= 1 && (owner ? rsp1_ready : rsp0_ready)) begin
                    busy = 1'b0;
                end else begin
                    age = 1;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
